// File: rtl/qux_source_if.sv
// Pull-protocol qux link: the source drives qux, the sink answers with quz to consume it.
interface intf;
  logic [31:0] qux;
  logic        quz;

  modport quxOut (output qux, input quz);
  modport quxIn  (input qux, output quz);
endinterface

// File: rtl/qux_source.sv
// Source end of the qux chain: buffers upstream words in a small FIFO and presents
// the head word (or IDLE_WORD when empty) from a flop, popping on each sink pull.
module qux_source #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] IDLE_WORD = 32'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  intf.quxOut                     qux_out,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        underrun_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] wr_next;
  logic [LW-1:0] level_next;
  logic [DW-1:0] qux_q;
  logic [DW-1:0] qux_next;
  logic          push;
  logic          pop;
  logic          underrun;

  // Handshake decode and next FIFO state; qux_next pre-computes the post-edge head.
  always_comb begin
    in_ready   = rst_n && (level < LW'(DEPTH)) && !flush;
    push       = in_valid && in_ready;
    pop        = qux_out.quz && (level != '0) && !flush;
    underrun   = qux_out.quz && (level == '0) && !flush;
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    level_next = level;
    qux_next   = IDLE_WORD;

    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      level_next = '0;
    end else begin
      if (pop)  rd_next = rd_ptr + PW'(1);
      if (push) wr_next = wr_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level_next = level + LW'(1);
        2'b01:   level_next = level - LW'(1);
        default: level_next = level;
      endcase
    end

    // A head landing on the slot being written this cycle must bypass the array.
    if (level_next != '0) begin
      if (push && (rd_next == wr_ptr)) qux_next = in_data;
      else                             qux_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      underrun_cnt <= '0;
      qux_q        <= IDLE_WORD;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      level  <= level_next;
      qux_q  <= qux_next;
      if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + CNT_W'(1);
    end
  end

  assign qux_out.qux = qux_q;

endmodule

// File: tb/tb_qux_source.sv
// Randomised and directed bench for qux_source against a queue-based reference model.
module tb_qux_source;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] IDLE  = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        quz;
  logic [2:0]  level;
  logic [15:0] underrun_cnt;
  logic        in_ready2;
  logic [2:0]  level2;
  logic [1:0]  underrun_cnt2;

  intf bus ();
  intf bus2 ();
  assign bus.quz  = quz;
  assign bus2.quz = quz;

  qux_source #(.DEPTH(DEPTH), .IDLE_WORD(IDLE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .qux_out(bus.quxOut),
    .level(level), .underrun_cnt(underrun_cnt)
  );

  qux_source #(.DEPTH(DEPTH), .IDLE_WORD(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .qux_out(bus2.quxOut),
    .level(level2), .underrun_cnt(underrun_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue of words, counters are saturating integers.
  logic [31:0] exp_q[$];
  int unsigned exp_und;
  int unsigned exp_und2;

  always @(posedge clk or negedge rst_n) begin
    int sz;
    if (!rst_n) begin
      exp_q.delete();
      exp_und  = 0;
      exp_und2 = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      if (quz && sz == 0) begin
        if (exp_und < 65535) exp_und++;
        if (exp_und2 < 3) exp_und2++;
      end
      if (quz && sz > 0) void'(exp_q.pop_front());
      if (in_valid && sz < int'(DEPTH)) exp_q.push_back(in_data);
    end
  end

  // Monitor: every cycle compare DUT outputs with the model; on a pull the presented
  // word is the one the sink consumes, so it must be the scoreboard head.
  always @(negedge clk) begin
    logic [31:0] exp_head;
    int          sz;
    sz       = exp_q.size();
    exp_head = (sz > 0) ? exp_q[0] : IDLE;
    check("level", 64'(level), 64'(sz));
    check("in_ready", 64'(in_ready), 64'(rst_n && sz < int'(DEPTH) && !flush));
    check("underrun_cnt", 64'(underrun_cnt), 64'(exp_und));
    check("underrun_sat", 64'(underrun_cnt2), 64'(exp_und2));
    if (quz && rst_n && !flush) check("qux_pop", 64'(bus.qux), 64'(exp_head));
    else                        check("qux_hold", 64'(bus.qux), 64'(exp_head));
  end

  task automatic step(input logic v, input logic [31:0] d, input logic q, input logic f);
    in_valid = v;
    in_data  = d;
    quz      = q;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    quz      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quz   = 1'b0;

    // Three consecutive pushes, no pulls.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);

    // Fill to DEPTH, hold a fifth word until one pull frees a slot, then drain.
    step(1'b1, 32'hD, 1'b0, 1'b0);
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b1, 32'hE, 1'b1, 1'b0);
    step(1'b1, 32'hE, 1'b0, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming push+pull across pointer wrap.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Pulls on an empty FIFO: 3, then 5 total (narrow counter saturates).
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush at level 3 with push and pull requested.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h2FF, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle at level 2.
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h301, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    quz   = 1'b1;
    #1;
    check("async_level", 64'(level), 64'd0);
    check("async_qux", 64'(bus.qux), 64'(IDLE));
    check("async_ready", 64'(in_ready), 64'd0);
    check("async_underrun", 64'(underrun_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quz   = 1'b0;
    step(1'b1, 32'h400, 1'b0, 1'b0);
    check("post_reset_qux", 64'(bus.qux), 64'h400);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, $urandom, ($urandom % 2) == 1, ($urandom % 32) == 0);

    step(1'b0, 32'h0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
